// File: rtl/pkg_led.sv
// Shared LED bank types and timing divisors.
package pkg_led;

  // Per-channel LED mode. Codes 6 and 7 are undefined and drive the LED off.
  typedef enum logic [2:0] {
    LED_OFF       = 3'd0,
    LED_ON        = 3'd1,
    LED_BLINK     = 3'd2,
    LED_BLINK_INV = 3'd3,
    LED_FLASH     = 3'd4,
    LED_HEARTBEAT = 3'd5
  } led_op_t;

  // Divisors applied to the clock frequency: blink half-period, flash on-time.
  localparam int unsigned BlinkDiv = 2;
  localparam int unsigned FlashDiv = 24;

endpackage

// File: rtl/dev_led_channel.sv
// One LED channel: registered mode, phase counter and waveform decode.
module dev_led_channel
  import pkg_led::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned BLINK    = CLK_FREQ / 2,
  parameter int unsigned FLASH    = CLK_FREQ / 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  led_op_t             op_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                pin_o
);

  localparam int unsigned CntW = $clog2(CLK_FREQ);

  localparam logic [CntW-1:0] BlinkC    = CntW'(BLINK);
  localparam logic [CntW-1:0] FlashC    = CntW'(FLASH);
  localparam logic [CntW-1:0] Flash2C   = CntW'(2 * FLASH);
  localparam logic [CntW-1:0] Flash3C   = CntW'(3 * FLASH);
  localparam logic [CntW-1:0] LastSlow  = CntW'(CLK_FREQ - 1);
  localparam logic [CntW-1:0] LastFlash = CntW'(2 * FLASH - 1);

  led_op_t         op_q;
  logic [CntW-1:0] count_q, count_d;
  logic            pin_q, pin_d;
  logic            pwm_on;
  logic [CntW-1:0] last;

  // Phase counter: restart on a mode change, otherwise count and wrap at the mode's period.
  always_comb begin
    last    = (op_q == LED_FLASH) ? LastFlash : LastSlow;
    count_d = count_q + CntW'(1);
    if (op_i != op_q) begin
      count_d = '0;
    end else if (count_q == last) begin
      count_d = '0;
    end
  end

  // Waveform decode from the current mode, phase and PWM gate.
  always_comb begin
    pwm_on = (pwm_cnt_i < duty_i) | (&duty_i);
    pin_d  = 1'b0;
    case (op_q)
      LED_OFF:       pin_d = 1'b0;
      LED_ON:        pin_d = pwm_on;
      LED_BLINK:     pin_d = (count_q < BlinkC) & pwm_on;
      LED_BLINK_INV: pin_d = (count_q >= BlinkC) & pwm_on;
      LED_FLASH:     pin_d = (count_q < FlashC) & pwm_on;
      LED_HEARTBEAT: pin_d = ((count_q < FlashC) |
                              ((count_q >= Flash2C) & (count_q < Flash3C))) & pwm_on;
      default:       pin_d = 1'b0;
    endcase
  end

  // Channel state; reset wins over mode changes and wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= LED_OFF;
      count_q <= '0;
      pin_q   <= 1'b0;
    end else begin
      op_q    <= op_i;
      count_q <= count_d;
      pin_q   <= pin_d;
    end
  end

  assign pin_o = pin_q;

endmodule

// File: rtl/dev_led_bank.sv
// Bank of independent LED channels sharing one PWM counter.
module dev_led_bank
  import pkg_led::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  led_op_t [NUM_LEDS-1:0]             op,
  input  logic    [NUM_LEDS-1:0][PWM_BITS-1:0] duty,
  output logic    [NUM_LEDS-1:0]             pin
);

  localparam int unsigned BLINK = CLK_FREQ / BlinkDiv;
  localparam int unsigned FLASH = CLK_FREQ / FlashDiv;

  logic [PWM_BITS-1:0] pwm_cnt_q;

  // Free-running PWM counter; wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : gen_chan
    dev_led_channel #(
      .CLK_FREQ (CLK_FREQ),
      .PWM_BITS (PWM_BITS),
      .BLINK    (BLINK),
      .FLASH    (FLASH)
    ) u_chan (
      .clk_i     (clk),
      .rst_i     (rst),
      .op_i      (op[i]),
      .duty_i    (duty[i]),
      .pwm_cnt_i (pwm_cnt_q),
      .pin_o     (pin[i])
    );
  end

endmodule

// File: doc/dev_led_bank.md
DEV_LED_BANK -- requirements
Module: dev_led_bank

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12_000_000, clock frequency in Hz; legal values are multiples of 24 and at least 48.
REQ-002 SHALL have parameter NUM_LEDS, default 4, number of independent LED channels (1..32).
REQ-003 SHALL have parameter PWM_BITS, default 8, brightness resolution (1..12).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port op, input, NUM_LEDS x pkg_led::led_op_t, per-channel mode.
REQ-007 SHALL have port duty, input, NUM_LEDS x PWM_BITS, per-channel brightness.
REQ-008 SHALL have port pin, output, NUM_LEDS, registered LED drive, 1 = lit.

Function
REQ-009 SHALL derive BLINK = CLK_FREQ/2 and FLASH = CLK_FREQ/24 as localparams.
REQ-010 SHALL run one shared PWM counter, 0..2^PWM_BITS-1, incrementing every cycle and wrapping to 0.
REQ-011 SHALL define pwm_on(i) = (pwm_cnt < duty[i]) OR (duty[i] all-ones); duty 0 gives never lit, all-ones gives always lit.
REQ-012 SHALL keep per channel a registered op_q and a phase counter of width $clog2(CLK_FREQ).
REQ-013 SHALL set the phase period to 2*FLASH cycles in LED_FLASH and to CLK_FREQ cycles in all other modes: count 0..period-1, then wrap to 0.
REQ-014 SHALL, when op[i] != op_q[i] at a rising edge, load op_q[i] <= op[i] and count[i] <= 0 on that edge, restarting the phase.
REQ-015 SHALL register pin[i] each cycle from op_q[i], count[i] and pwm_on(i); a new op reaches pin on the second rising edge after it is presented, starting at phase 0.
REQ-016 SHALL decode LED_OFF as 0 and LED_ON as pwm_on.
REQ-017 SHALL decode LED_BLINK as (count < BLINK) & pwm_on, and LED_BLINK_INV as (count >= BLINK) & pwm_on.
REQ-018 SHALL decode LED_FLASH as (count < FLASH) & pwm_on.
REQ-019 SHALL decode the new mode LED_HEARTBEAT as ((count < FLASH) | (2*FLASH <= count < 3*FLASH)) & pwm_on, with period CLK_FREQ.
REQ-020 SHALL drive 0 for any undefined op code and SHALL still restart the phase on a change to it.
REQ-021 SHALL apply duty changes without a phase restart, with a latency of one cycle.
REQ-022 SHALL keep channels independent: an op change on channel i SHALL NOT affect the count or pin of any channel j != i.
REQ-023 SHALL let two channels given the same op on the same cycle stay phase-locked indefinitely.

Reset
REQ-024 SHALL, on rst high at a rising edge, set pwm_cnt=0, every count=0, every op_q=LED_OFF and every pin=0.
REQ-025 SHALL give rst priority over op-change and wrap logic, and SHALL restart any operation in progress when asserted mid-operation.
REQ-026 SHALL treat op sampled on the first edge after rst falls as a change when it differs from LED_OFF.

Structure
REQ-027 SHALL put led_op_t, extended with LED_HEARTBEAT (existing encodings unchanged), in pkg_led.
REQ-028 SHALL put BLINK and FLASH divisor constants (2, 24) in pkg_led.
REQ-029 SHALL implement the per-channel op_q, counter and decode as sub-module dev_led_channel, generated NUM_LEDS times, with the PWM counter in the top.

Verification
REQ-030 SHALL use test parameters CLK_FREQ=48, NUM_LEDS=2, PWM_BITS=2, giving BLINK=24 and FLASH=2.
REQ-031 SHALL cover: rst high for 3 cycles, then op=LED_BLINK, duty=3 -> pin[0] is 0 for 2 edges, then 1 for 24 cycles, 0 for 24 cycles, repeating.
REQ-032 SHALL cover: LED_FLASH, duty=3 -> pin high 2 cycles out of every 4.
REQ-033 SHALL cover: LED_ON, duty=1 -> pin high 1 of every 4 cycles; duty=0 -> always 0; duty=3 -> always 1.
REQ-034 SHALL cover: LED_HEARTBEAT, duty=3 -> pin high at phases 0-1 and 4-5 of every 48 cycles.
REQ-035 SHALL cover: channel 0 switched from BLINK to BLINK_INV at phase 10 while channel 1 stays BLINK -> channel 0 restarts at phase 0 (low for 24 cycles) and channel 1's waveform is undisturbed.
REQ-036 SHALL cover: rst asserted at phase 30 of BLINK -> all pins 0 the next cycle, and BLINK restarts at phase 0 after release.
